// File: rtl/external_segment_decoder.sv
// Receive end of the Pmod segment link: synchronise, debounce and decode
// the 8-bit pattern bus back to a level tier (1..4).
module external_segment_decoder #(
    parameter int STABLE_CYCLES = 1000,
    parameter int CNT_W         = 10
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] seg_in,
    output logic [2:0] tier,
    output logic       tier_valid,
    output logic       tier_changed,
    output logic       bad_pattern
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        LOCKED
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [7:0]       sync1_q, sync1_d;
    logic [7:0]       sync2_q, sync2_d;
    logic [7:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       tier_q, tier_d;
    logic             tier_valid_q, tier_valid_d;
    logic             tier_changed_q, tier_changed_d;
    logic             bad_pattern_q, bad_pattern_d;

    logic [2:0]       code;
    logic             code_ok;
    logic             accept;

    always_comb begin
        code    = 3'd0;
        code_ok = 1'b1;
        unique case (cand_q)
            8'b00001011: code = 3'd1;
            8'b10111101: code = 3'd2;
            8'b10011111: code = 3'd3;
            8'b00001000: code = 3'd4;
            default:     code_ok = 1'b0;
        endcase
    end

    always_comb begin
        sync1_d        = seg_in;
        sync2_d        = sync1_q;
        state_d        = state_q;
        cand_d         = cand_q;
        cnt_d          = cnt_q;
        accept         = 1'b0;
        unique case (state_q)
            IDLE: begin
                cand_d  = sync2_q;
                cnt_d   = '0;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (sync2_q != cand_q) begin
                    cand_d = sync2_q;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                    state_d = LOCKED;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LOCKED: begin
                if (sync2_q != cand_q) begin
                    cand_d  = sync2_q;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs only move on an accepting edge; glitches merely restart the count.
    always_comb begin
        tier_d         = tier_q;
        tier_valid_d   = tier_valid_q;
        bad_pattern_d  = bad_pattern_q;
        tier_changed_d = 1'b0;
        if (accept) begin
            if (code_ok) begin
                tier_d         = code;
                tier_valid_d   = 1'b1;
                bad_pattern_d  = 1'b0;
                tier_changed_d = !tier_valid_q || (tier_q != code);
            end else begin
                tier_d        = 3'd0;
                tier_valid_d  = 1'b0;
                bad_pattern_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q        <= IDLE;
            sync1_q        <= 8'h00;
            sync2_q        <= 8'h00;
            cand_q         <= 8'h00;
            cnt_q          <= '0;
            tier_q         <= 3'd0;
            tier_valid_q   <= 1'b0;
            tier_changed_q <= 1'b0;
            bad_pattern_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            cand_q         <= cand_d;
            cnt_q          <= cnt_d;
            tier_q         <= tier_d;
            tier_valid_q   <= tier_valid_d;
            tier_changed_q <= tier_changed_d;
            bad_pattern_q  <= bad_pattern_d;
        end
    end

    assign tier         = tier_q;
    assign tier_valid   = tier_valid_q;
    assign tier_changed = tier_changed_q;
    assign bad_pattern  = bad_pattern_q;

endmodule

// File: tb/tb_external_segment_decoder.sv
// Directed-vector bench for external_segment_decoder with a short
// debounce window so every latency can be counted edge by edge.
module tb_external_segment_decoder;

    localparam int SC = 4;

    logic       clock = 1'b0;
    logic       resetn;
    logic [7:0] seg_in;
    logic [2:0] tier;
    logic       tier_valid;
    logic       tier_changed;
    logic       bad_pattern;

    int checks = 0;
    int errors = 0;

    external_segment_decoder #(
        .STABLE_CYCLES(SC),
        .CNT_W        (3)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .seg_in      (seg_in),
        .tier        (tier),
        .tier_valid  (tier_valid),
        .tier_changed(tier_changed),
        .bad_pattern (bad_pattern)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges; observe/drive 1 time unit after the last edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic outs(input string tag, input logic [2:0] t,
                        input logic v, input logic c, input logic b);
        chk({tag, ".tier"}, {5'd0, tier}, {5'd0, t});
        chk({tag, ".valid"}, {7'd0, tier_valid}, {7'd0, v});
        chk({tag, ".chg"}, {7'd0, tier_changed}, {7'd0, c});
        chk({tag, ".bad"}, {7'd0, bad_pattern}, {7'd0, b});
    endtask

    logic seen;

    initial begin
        resetn = 1'b0;
        seg_in = 8'b00001011;
        tick(2);
        outs("rst", 3'd0, 1'b0, 1'b0, 1'b0);

        // Release: cand of 00 at E1, real pattern captured at E3, accept at E7.
        resetn = 1'b1;
        tick(6);
        outs("t1_pre", 3'd0, 1'b0, 1'b0, 1'b0);
        tick(1);
        outs("t1_acc", 3'd1, 1'b1, 1'b1, 1'b0);
        tick(1);
        outs("t1_pulse_end", 3'd1, 1'b1, 1'b0, 1'b0);

        // Tier 1 -> 3: sampled at edge k, accepted at k+6.
        seg_in = 8'b10011111;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk("t3_hold", {5'd0, tier}, 8'd1);
        end
        tick(1);
        outs("t3_acc", 3'd3, 1'b1, 1'b1, 1'b0);

        // Move to tier 2, then a 2-cycle glitch that returns to tier 2.
        seg_in = 8'b10111101;
        tick(7);
        outs("t2_acc", 3'd2, 1'b1, 1'b1, 1'b0);
        tick(1);
        seg_in = 8'h00;
        tick(2);
        seg_in = 8'b10111101;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (tier_changed || tier != 3'd2 || !tier_valid || bad_pattern)
                seen = 1'b1;
        end
        chk("glitch_disturb", {7'd0, seen}, 8'd0);
        outs("glitch_end", 3'd2, 1'b1, 1'b0, 1'b0);

        // Unrecognised pattern, then tier 4.
        seg_in = 8'hFF;
        tick(8);
        outs("bad", 3'd0, 1'b0, 1'b0, 1'b1);
        seg_in = 8'b00001000;
        tick(6);
        outs("t4_pre", 3'd0, 1'b0, 1'b0, 1'b1);
        tick(1);
        outs("t4_acc", 3'd4, 1'b1, 1'b1, 1'b0);
        tick(1);
        outs("t4_pulse_end", 3'd4, 1'b1, 1'b0, 1'b0);

        // Reset while cnt==2 (edges k..k+4), then re-debounce.
        seg_in = 8'b00001011;
        tick(5);
        outs("mid_settle", 3'd4, 1'b1, 1'b0, 1'b0);
        resetn = 1'b0;
        tick(1);
        outs("mid_rst", 3'd0, 1'b0, 1'b0, 1'b0);
        resetn = 1'b1;
        tick(6);
        outs("rea_pre", 3'd0, 1'b0, 1'b0, 1'b0);
        tick(1);
        outs("rea_acc", 3'd1, 1'b1, 1'b1, 1'b0);
        tick(1);

        // Toggle every 3 cycles: counter never completes.
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (i % 3 == 0)
                seg_in = ((i / 3) % 2 == 0) ? 8'b10011111 : 8'hFF;
            tick(1);
            if (tier_changed || tier != 3'd1 || !tier_valid || bad_pattern)
                seen = 1'b1;
        end
        chk("toggle_disturb", {7'd0, seen}, 8'd0);
        outs("toggle_end", 3'd1, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
